// File: rtl/mux4_arbiter_pkg.sv
// mux4_arbiter_pkg: shared definitions for the 4-way round-robin arbiter.
//   state_e      : FSM state encoding (IDLE=0, GRANT=1, GAP=2), 2 bits
//   MAX_HOLD_DEF : default maximum grant length used with ARB_TIMEOUT_EN
//   IDX_W        : width of a requester index
package mux4_arbiter_pkg;

  localparam int IDX_W        = 2;
  localparam int MAX_HOLD_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

endpackage

// File: rtl/mux4_arbiter_rr_pick4.sv
// rr_pick4: combinational round-robin picker.
//   req_i   [3:0] : request vector
//   ptr_i   [1:0] : highest-priority index; scan order is ptr, ptr+1, ... mod 4
//   valid_o       : at least one request is set
//   idx_o   [1:0] : index of the first set request in scan order
module rr_pick4
  import mux4_arbiter_pkg::*;
(
  input  logic [3:0]       req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down so the nearest set request wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr_i + IDX_W'(i);
      if (req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_arbiter.sv
// mux4_arbiter: 4-requester round-robin arbiter with a registered 4:1 data mux.
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   req  [3:0] : level-sensitive requests
//   dat  [3:0] : one data bit per requester
//   gnt  [3:0] : one-hot registered grant
//   sel  [1:0] : registered index of the granted requester (mux select)
//   o          : registered dat[sel] while granted, else 0
//   busy       : high in GRANT
// Optional feature: define ARB_TIMEOUT_EN to force a release after MAX_HOLD
// grant cycles (MAX_HOLD legal range 2..15).
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no grant; arbitrate from ptr on any request
// ST_GRANT | one requester owns the mux; held until its req drops
// ST_GAP   | one dead cycle after a release; ptr already advanced
module mux4_arbiter
  import mux4_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [3:0]       dat,
  output logic [3:0]       gnt,
  output logic [IDX_W-1:0] sel,
  output logic             o,
  output logic             busy
);

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             o_q, o_d;

  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;
  logic             hold_done;
  logic             release_now;

  rr_pick4 u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .valid_o (pick_vld),
    .idx_o   (pick_idx)
  );

  assign hold_done = (cnt_q == HOLD_LAST);

`ifdef ARB_TIMEOUT_EN
  // A dropped request and a timeout on the same edge are one release.
  assign release_now = !req[sel_q] || hold_done;
`else
  assign release_now = !req[sel_q];
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    o_d     = o_q;
    // Without the timeout the counter just wraps at MAX_HOLD and is unused.
    cnt_d   = hold_done ? 4'd0 : cnt_q + 4'd1;

    unique case (state_q)
      ST_IDLE, ST_GAP: begin
        gnt_d = '0;
        o_d   = 1'b0;
        cnt_d = '0;
        if (pick_vld) begin
          state_d = ST_GRANT;
          gnt_d   = 4'b0001 << pick_idx;
          sel_d   = pick_idx;
          o_d     = dat[pick_idx];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        o_d = dat[sel_q];
        if (release_now) begin
          state_d = ST_GAP;
          gnt_d   = '0;
          o_d     = 1'b0;
          cnt_d   = '0;
          ptr_d   = sel_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        o_d     = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      o_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign o    = o_q;
  assign busy = (state_q == ST_GRANT);

endmodule

// File: tb/tb_mux4_arbiter.sv
module tb_mux4_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int MH  = 4;
  localparam bit TMO = 1'b1;
`else
  localparam int MH  = 8;
  localparam bit TMO = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req   = 4'b0;
  logic [3:0] dat   = 4'b0;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       o;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: who owns the bus, for how long, and where the next scan starts.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_sel   = 0;
  int m_held  = 0;
  bit m_o     = 1'b0;

  always #5 clk = ~clk;

  mux4_arbiter #(.MAX_HOLD(MH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .dat   (dat),
    .gnt   (gnt),
    .sel   (sel),
    .o     (o),
    .busy  (busy)
  );

  task automatic model_clear();
    m_owner = -1;
    m_ptr   = 0;
    m_sel   = 0;
    m_held  = 0;
    m_o     = 1'b0;
  endtask

  task automatic model_step();
    bit found;
    if (!rst_n) begin
      model_clear();
    end else if (m_owner >= 0) begin
      if (!req[m_owner] || (TMO && m_held == MH)) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
        m_o     = 1'b0;
      end else begin
        m_held++;
        m_o = dat[m_owner];
      end
    end else begin
      m_o   = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (!found && req[(m_ptr + k) % 4]) begin
          found   = 1'b1;
          m_owner = (m_ptr + k) % 4;
          m_sel   = m_owner;
          m_held  = 1;
          m_o     = dat[m_owner];
        end
      end
    end
  endtask

  function automatic logic [7:0] model_vec();
    logic [3:0] g;
    g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
    return {g, 2'(m_sel), m_o, (m_owner >= 0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0;
    dat   = 4'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'hF;
    dat   = 4'hF;
    repeat (2) tick();
    n_cmp++;
    if ({gnt, sel, o, busy} !== 8'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got gnt=%b sel=%0d o=%b busy=%b, want all 0", gnt, sel, o, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (gnt !== 4'b0001 || sel !== 2'd0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL first_grant_req0: got gnt=%b sel=%0d busy=%b, want 0001/0/1", gnt, sel, busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    dat = 4'($urandom);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (gnt !== 4'b0100 || sel !== 2'd2 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL single_grant[%0d]: got gnt=%b sel=%0d busy=%b, want 0100/2/1", i, gnt, sel, busy);
      end
    end
    req = 4'b0000;
    tick();
    n_cmp++;
    if (gnt !== 4'b0 || busy !== 1'b0 || o !== 1'b0 || sel !== 2'd2) begin
      n_err++;
      $display("FAIL single_gap: got gnt=%b busy=%b o=%b sel=%0d, want 0000/0/0/2", gnt, busy, o, sel);
    end
    tick();
    n_cmp++;
    if (gnt !== 4'b0 || busy !== 1'b0 || o !== 1'b0) begin
      n_err++;
      $display("FAIL single_idle: got gnt=%b busy=%b o=%b, want 0000/0/0", gnt, busy, o);
    end
    req = 4'b1111;
    tick();
    n_cmp++;
    if (gnt !== 4'b1000 || sel !== 2'd3) begin
      n_err++;
      $display("FAIL ptr_after_release: got gnt=%b sel=%0d, want 1000/3", gnt, sel);
    end
    req = 4'b0;
    tick();
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    tick();
    req = 4'b0001;
    tick();
    n_cmp++;
    if (gnt !== 4'b0001 || sel !== 2'd0) begin
      n_err++;
      $display("FAIL wrap_to_0: got gnt=%b sel=%0d, want 0001/0", gnt, sel);
    end
    req = 4'b1000;
    tick();
    n_cmp++;
    if (gnt !== 4'b0000) begin
      n_err++;
      $display("FAIL wrap_gap: got gnt=%b, want 0000", gnt);
    end
    req = 4'b1001;
    tick();
    n_cmp++;
    if (gnt !== 4'b1000 || sel !== 2'd3) begin
      n_err++;
      $display("FAIL wrap_next_3: got gnt=%b sel=%0d, want 1000/3", gnt, sel);
    end
    req = 4'b0;
    tick();
    tick();
  endtask

  task automatic test_dat();
    logic [3:0] dseq [6] = '{4'b0010, 4'b1101, 4'b0010, 4'b1111, 4'b0010, 4'b1011};
    logic       oexp [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int g = 0; g < 2; g++) begin
      req = 4'b0010;
      for (int i = 0; i < 3; i++) begin
        dat = dseq[g*3 + i];
        tick();
        n_cmp++;
        if (gnt !== 4'b0010 || o !== oexp[g*3 + i]) begin
          n_err++;
          $display("FAIL dat_follow[%0d]: got gnt=%b o=%b, want 0010/%b", g*3 + i, gnt, o, oexp[g*3 + i]);
        end
      end
      req = 4'b0;
      tick();
      tick();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b0100;
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    model_clear();
    n_cmp++;
    if (gnt !== 4'b0 || busy !== 1'b0 || o !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got gnt=%b busy=%b o=%b before next edge, want 0000/0/0", gnt, busy, o);
    end
    #2;
    rst_n = 1'b1;
    req   = 4'b1000;
    tick();
    n_cmp++;
    if (gnt !== 4'b1000 || sel !== 2'd3) begin
      n_err++;
      $display("FAIL post_reset_grant: got gnt=%b sel=%0d, want 1000/3", gnt, sel);
    end
    req = 4'b0;
    tick();
    tick();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [3:0] exp;
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 25; c++) begin
      tick();
      exp = ((c % 5) < 4) ? 4'(1 << ((c / 5) % 4)) : 4'b0;
      n_cmp++;
      if (gnt !== exp || busy !== (exp != 4'b0)) begin
        n_err++;
        $display("FAIL timeout_rotate[%0d]: got gnt=%b busy=%b, want %b", c, gnt, busy, exp);
      end
    end
    // Request drop coinciding with the timeout edge: one gap, then the next owner.
    do_reset();
    req = 4'b0011;
    repeat (4) tick();
    req = 4'b0010;
    tick();
    n_cmp++;
    if (gnt !== 4'b0000) begin
      n_err++;
      $display("FAIL timeout_and_drop_gap: got gnt=%b, want 0000", gnt);
    end
    tick();
    n_cmp++;
    if (gnt !== 4'b0010 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_and_drop_next: got gnt=%b busy=%b, want 0010/1", gnt, busy);
    end
    req = 4'b0;
    tick();
    tick();
  endtask
`else
  task automatic test_no_timeout();
    do_reset();
    req = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      dat = 4'($urandom);
      tick();
      n_cmp++;
      if (gnt !== 4'b0010 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL long_hold[%0d]: got gnt=%b busy=%b, want 0010/1", c, gnt, busy);
      end
    end
    req = 4'b0;
    tick();
    tick();
  endtask
`endif

  task automatic test_random();
    logic [7:0] exp;
    logic [3:0] prev_gnt;
    do_reset();
    prev_gnt = 4'b0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      dat = 4'($urandom);
      tick();
      exp = model_vec();
      n_cmp++;
      if ({gnt, sel, o, busy} !== exp) begin
        n_err++;
        $display("FAIL random[%0d]: got gnt=%b sel=%0d o=%b busy=%b, want gnt=%b sel=%0d o=%b busy=%b",
                 c, gnt, sel, o, busy, exp[7:4], exp[3:2], exp[1], exp[0]);
      end
      n_cmp++;
      if (!$onehot0(gnt) || (prev_gnt != 4'b0 && gnt != 4'b0 && gnt !== prev_gnt)) begin
        n_err++;
        $display("FAIL grant_rules[%0d]: got gnt=%b after %b, want one-hot and no direct switch", c, gnt, prev_gnt);
      end
      prev_gnt = gnt;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_dat();
    test_async_reset();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
